// File: rtl/usb_pkg.sv
// Shared USB receive/transmit constants and PID classification.
//   SYNC         : byte that precedes every packet
//   PID_*        : PID group code tables (upper nibble)
//   pid_class_t  : PID group
//   classify()   : group of a full PID byte, INVALID on a bad check nibble
package usb_pkg;
  localparam logic [7:0] SYNC = 8'h80;

  localparam logic [3:0][3:0] PID_TOKEN   = {4'b1101, 4'b0101, 4'b1001, 4'b0001};
  localparam logic [3:0][3:0] PID_DATA    = {4'b1111, 4'b0111, 4'b1011, 4'b0011};
  localparam logic [3:0][3:0] PID_HAND    = {4'b0110, 4'b1110, 4'b1010, 4'b0010};
  localparam logic [2:0][3:0] PID_SPECIAL = {4'b0100, 4'b1000, 4'b1100};

  typedef enum logic [2:0] {TOKEN, DATA, HAND, SPECIAL, INVALID} pid_class_t;

  function automatic pid_class_t classify(input logic [7:0] pid);
    pid_class_t c;
    c = INVALID;
    if (pid[3:0] == ~pid[7:4]) begin
      for (int i = 0; i < 4; i++) begin
        if (pid[7:4] == PID_TOKEN[i]) c = TOKEN;
        if (pid[7:4] == PID_DATA[i])  c = DATA;
        if (pid[7:4] == PID_HAND[i])  c = HAND;
      end
      for (int i = 0; i < 3; i++)
        if (pid[7:4] == PID_SPECIAL[i]) c = SPECIAL;
    end
    return c;
  endfunction
endpackage

// File: rtl/crc_hold_buffer.sv
// Two-entry byte delay line holding the most recent data-packet bytes so
// the trailing two (the CRC) can be steered away from the payload FIFO.
//   clr    : empty the buffer (wins over push/pop)
//   push   : append din
//   pop    : drop the oldest entry (push+pop when full shifts in din)
//   oldest : oldest held byte; newest: most recent held byte
//   occ    : number of held bytes, 0..2
module crc_hold_buffer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] oldest,
  output logic [7:0] newest,
  output logic [1:0] occ
);
  logic [7:0] b0, b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      b0 <= '0; b1 <= '0; occ <= '0;
    end else if (clr) begin
      b0 <= '0; b1 <= '0; occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0)      begin b0 <= din; occ <= 2'd1; end
          else if (occ == 2'd1) begin b1 <= din; occ <= 2'd2; end
        end
        2'b01: begin
          if (occ != 2'd0) begin b0 <= b1; occ <= occ - 2'd1; end
        end
        2'b11: begin
          if (occ == 2'd2) begin b0 <= b1; b1 <= din; end
          else begin b0 <= din; occ <= 2'd1; end
        end
        default: ;
      endcase
    end
  end

  assign oldest = b0;
  assign newest = (occ == 2'd2) ? b1 : b0;
endmodule

// File: rtl/rrcu.sv
// USB receive control unit: strips SYNC, classifies the PID and routes
// packet bytes into the PID / non-data / data / data-CRC FIFOs.
//   clk, n_rst         : clock, async active-low reset
//   byte_valid,rx_byte : decoded byte strobe and value
//   eop                : end-of-packet strobe
//   *_full             : FIFO full flags
//   write_data, *_write: registered FIFO write port (one strobe at a time)
//   pkt_done/pkt_error : packet accepted / rejected pulses
//   rx_busy            : not idle
module rrcu
  import usb_pkg::*;
#(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       pid_full,
  input  logic       nd_full,
  input  logic       data_full,
  input  logic       dcrc_full,
  output logic [7:0] write_data,
  output logic       pid_write,
  output logic       nd_write,
  output logic       data_write,
  output logic       dcrc_write,
  output logic       pkt_done,
  output logic       pkt_error,
  output logic       rx_busy
);
  localparam int CW = $clog2(MAX_DATA + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_PID, S_GET_ND, S_GET_DATA, S_FLUSH_CRC1,
    S_FLUSH_CRC2, S_WAIT_EOP, S_COMMIT, S_ERROR
  } state_t;

  state_t        state, nxt;
  logic [7:0]    pid_q, pid_d;
  logic [1:0]    nd_left, nd_left_d;
  logic [CW-1:0] count, count_d;
  logic          eop_pend, eop_i;
  logic [7:0]    wd;
  logic          wr_pid, wr_nd, wr_data, wr_dcrc, done_d, err_d;
  logic          hb_clr, hb_push, hb_pop;
  logic [7:0]    hb_old, hb_new;
  logic [1:0]    hb_occ;

  crc_hold_buffer u_hold (
    .clk(clk), .n_rst(n_rst), .clr(hb_clr), .push(hb_push), .pop(hb_pop),
    .din(rx_byte), .oldest(hb_old), .newest(hb_new), .occ(hb_occ)
  );

  // An eop that shares a cycle with a byte is deferred one cycle so the
  // byte is handled first.
  assign eop_i = eop_pend | (eop & ~byte_valid);

  always_comb begin
    nxt = state; pid_d = pid_q; nd_left_d = nd_left; count_d = count;
    wd = '0; wr_pid = 1'b0; wr_nd = 1'b0; wr_data = 1'b0; wr_dcrc = 1'b0;
    done_d = 1'b0; err_d = 1'b0;
    hb_clr = 1'b0; hb_push = 1'b0; hb_pop = 1'b0;
    case (state)
      S_IDLE: if (byte_valid && rx_byte == SYNC) nxt = S_GET_PID;
      S_GET_PID: begin
        if (byte_valid) begin
          pid_d = rx_byte;
          case (classify(rx_byte))
            TOKEN, SPECIAL: begin nxt = S_GET_ND; nd_left_d = 2'd2; end
            DATA:           begin nxt = S_GET_DATA; count_d = '0; hb_clr = 1'b1; end
            HAND:           nxt = S_WAIT_EOP;
            default:        begin nxt = S_ERROR; err_d = 1'b1; end
          endcase
        end else if (eop_i) begin
          nxt = S_IDLE; err_d = 1'b1;
        end
      end
      S_GET_ND: begin
        if (byte_valid) begin
          if (nd_full) begin
            nxt = S_ERROR; err_d = 1'b1;
          end else begin
            wr_nd = 1'b1; wd = rx_byte; nd_left_d = nd_left - 2'd1;
            if (nd_left == 2'd1) nxt = S_WAIT_EOP;
          end
        end else if (eop_i) begin
          nxt = S_IDLE; err_d = 1'b1;
        end
      end
      S_GET_DATA: begin
        if (byte_valid) begin
          if (hb_occ != 2'd2) begin
            hb_push = 1'b1;
          end else if (count == CW'(MAX_DATA) || data_full) begin
            nxt = S_ERROR; err_d = 1'b1;
          end else begin
            wr_data = 1'b1; wd = hb_old; count_d = count + 1'b1;
            hb_push = 1'b1; hb_pop = 1'b1;
          end
        end else if (eop_i) begin
          // eop is consumed here, so every failure returns straight to IDLE
          if (hb_occ == 2'd2 && !dcrc_full) begin
            nxt = S_FLUSH_CRC1; wr_dcrc = 1'b1; wd = hb_old;
          end else begin
            nxt = S_IDLE; err_d = 1'b1;
          end
        end
      end
      S_FLUSH_CRC1: begin
        if (dcrc_full) begin nxt = S_IDLE; err_d = 1'b1; end
        else begin nxt = S_FLUSH_CRC2; wr_dcrc = 1'b1; wd = hb_new; end
      end
      S_FLUSH_CRC2: begin
        if (pid_full) begin nxt = S_IDLE; err_d = 1'b1; end
        else begin nxt = S_COMMIT; wr_pid = 1'b1; wd = pid_q; done_d = 1'b1; end
      end
      S_WAIT_EOP: begin
        if (byte_valid) begin
          nxt = S_ERROR; err_d = 1'b1;
        end else if (eop_i) begin
          if (pid_full) begin nxt = S_IDLE; err_d = 1'b1; end
          else begin nxt = S_COMMIT; wr_pid = 1'b1; wd = pid_q; done_d = 1'b1; end
        end
      end
      S_COMMIT: nxt = S_IDLE;
      S_ERROR:  if (eop_i) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are registered alongside the state, so the write/pulse of a
  // state is visible in the cycle that state is occupied.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE; pid_q <= '0; nd_left <= '0; count <= '0; eop_pend <= 1'b0;
      write_data <= '0; pid_write <= 1'b0; nd_write <= 1'b0; data_write <= 1'b0;
      dcrc_write <= 1'b0; pkt_done <= 1'b0; pkt_error <= 1'b0; rx_busy <= 1'b0;
    end else begin
      state <= nxt; pid_q <= pid_d; nd_left <= nd_left_d; count <= count_d;
      eop_pend <= byte_valid & eop;
      write_data <= wd; pid_write <= wr_pid; nd_write <= wr_nd;
      data_write <= wr_data; dcrc_write <= wr_dcrc;
      pkt_done <= done_d; pkt_error <= err_d; rx_busy <= (nxt != S_IDLE);
    end
  end
endmodule

// File: tb/tb_rrcu.sv
module tb_rrcu;
  localparam int MAX_DATA = 64;

  typedef struct { logic [7:0] d; int c; } ev_t;

  logic clk = 1'b0, n_rst;
  logic byte_valid, eop, pid_full, nd_full, data_full, dcrc_full;
  logic [7:0] rx_byte, write_data;
  logic pid_write, nd_write, data_write, dcrc_write, pkt_done, pkt_error, rx_busy;
  logic [14:0] outv;

  rrcu #(.MAX_DATA(MAX_DATA)) dut (
    .clk(clk), .n_rst(n_rst), .byte_valid(byte_valid), .rx_byte(rx_byte), .eop(eop),
    .pid_full(pid_full), .nd_full(nd_full), .data_full(data_full), .dcrc_full(dcrc_full),
    .write_data(write_data), .pid_write(pid_write), .nd_write(nd_write),
    .data_write(data_write), .dcrc_write(dcrc_write), .pkt_done(pkt_done),
    .pkt_error(pkt_error), .rx_busy(rx_busy)
  );

  assign outv = {write_data, pid_write, nd_write, data_write, dcrc_write,
                 pkt_done, pkt_error, rx_busy};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t pid_q[$], nd_q[$], dat_q[$], crc_q[$];
  int  done_q[$], err_q[$];
  int  multi, nerr = 0, nchk = 0, bcyc, ecyc, b1, b2;

  always @(negedge clk) begin
    if (pid_write)  pid_q.push_back('{write_data, cyc});
    if (nd_write)   nd_q.push_back('{write_data, cyc});
    if (data_write) dat_q.push_back('{write_data, cyc});
    if (dcrc_write) crc_q.push_back('{write_data, cyc});
    if (pkt_done)   done_q.push_back(cyc);
    if (pkt_error)  err_q.push_back(cyc);
    if ($countones({pid_write, nd_write, data_write, dcrc_write}) > 1) multi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // k: 0 pid, 1 nd, 2 data, 3 dcrc; c < 0 skips the cycle check
  task automatic chk_ev(input string tag, input int k, input int i,
                        input logic [7:0] d, input int c);
    ev_t e;
    e = '{8'h00, -1};
    case (k)
      0: if (i < pid_q.size()) e = pid_q[i];
      1: if (i < nd_q.size())  e = nd_q[i];
      2: if (i < dat_q.size()) e = dat_q[i];
      default: if (i < crc_q.size()) e = crc_q[i];
    endcase
    chk({tag, "_d"}, e.d, d);
    if (c >= 0) chk({tag, "_c"}, e.c, c);
  endtask

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic clr_log();
    pid_q.delete(); nd_q.delete(); dat_q.delete(); crc_q.delete();
    done_q.delete(); err_q.delete(); multi = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1; byte_valid = 1'b1; rx_byte = b; bcyc = cyc;
    @(posedge clk); #1; byte_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic send_eop();
    @(posedge clk); #1; eop = 1'b1; ecyc = cyc;
    @(posedge clk); #1; eop = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; byte_valid = 1'b0; rx_byte = '0; eop = 1'b0;
    pid_full = 1'b0; nd_full = 1'b0; data_full = 1'b0; dcrc_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_out", outv, 15'd0);
    n_rst = 1'b1;
    settle();

    // handshake
    clr_log();
    send_byte(8'h80); chk("hs_busy", rx_busy, 1);
    send_byte(8'h2D); send_eop(); settle();
    chk("hs_npid", pid_q.size(), 1);
    chk_ev("hs_pid", 0, 0, 8'h2D, ecyc + 1);
    chk("hs_done", first(done_q), ecyc + 1);
    chk("hs_other", nd_q.size() + dat_q.size() + crc_q.size() + err_q.size(), 0);
    chk("hs_idle", rx_busy, 0);

    // token
    clr_log();
    send_byte(8'h80); send_byte(8'h1E);
    send_byte(8'hA5); b1 = bcyc;
    send_byte(8'h3C); b2 = bcyc;
    send_eop(); settle();
    chk("tk_nnd", nd_q.size(), 2);
    chk_ev("tk_nd0", 1, 0, 8'hA5, b1 + 1);
    chk_ev("tk_nd1", 1, 1, 8'h3C, b2 + 1);
    chk_ev("tk_pid", 0, 0, 8'h1E, ecyc + 1);
    chk("tk_done", first(done_q), ecyc + 1);
    chk("tk_other", dat_q.size() + crc_q.size() + err_q.size(), 0);

    // data
    clr_log();
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); b1 = bcyc;
    send_byte(8'hC1); send_byte(8'hC2); send_eop(); settle();
    chk("dt_ndat", dat_q.size(), 3);
    chk_ev("dt_d0", 2, 0, 8'h11, b1 + 1);
    chk_ev("dt_d1", 2, 1, 8'h22, -1);
    chk_ev("dt_d2", 2, 2, 8'h33, -1);
    chk("dt_ncrc", crc_q.size(), 2);
    chk_ev("dt_crc0", 3, 0, 8'hC1, ecyc + 1);
    chk_ev("dt_crc1", 3, 1, 8'hC2, ecyc + 2);
    chk_ev("dt_pid", 0, 0, 8'h3C, ecyc + 3);
    chk("dt_done", first(done_q), ecyc + 3);
    chk("dt_other", nd_q.size() + err_q.size() + multi, 0);

    // bad check nibble
    clr_log();
    send_byte(8'h80); send_byte(8'h1F); b1 = bcyc;
    send_eop(); settle();
    chk("bp_err", first(err_q), b1 + 1);
    chk("bp_nerr", err_q.size(), 1);
    chk("bp_npid", pid_q.size() + done_q.size(), 0);
    chk("bp_idle", rx_busy, 0);

    // short token
    clr_log();
    send_byte(8'h80); send_byte(8'h1E); send_byte(8'hA5); send_eop(); settle();
    chk("st_err", first(err_q), ecyc + 1);
    chk("st_npid", pid_q.size() + done_q.size(), 0);
    chk("st_nnd", nd_q.size(), 1);

    // CRC missing
    clr_log();
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11); send_eop(); settle();
    chk("cm_err", first(err_q), ecyc + 1);
    chk("cm_none", pid_q.size() + done_q.size() + dat_q.size() + crc_q.size(), 0);

    // payload overflow: MAX_DATA+3 bytes after the PID
    clr_log();
    send_byte(8'h80); send_byte(8'h3C);
    for (int i = 0; i < MAX_DATA + 3; i++) send_byte(8'(i + 1));
    b1 = bcyc;
    send_eop(); settle();
    chk("of_err", first(err_q), b1 + 1);
    chk("of_ndat", dat_q.size(), MAX_DATA);
    chk_ev("of_last", 2, MAX_DATA - 1, 8'(MAX_DATA), -1);
    chk("of_none", pid_q.size() + done_q.size() + crc_q.size(), 0);
    chk("of_idle", rx_busy, 0);

    // overrun on the data FIFO
    clr_log();
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11); send_byte(8'h22);
    data_full = 1'b1; send_byte(8'h33); b1 = bcyc; data_full = 1'b0;
    chk("ov_busy", rx_busy, 1);
    send_byte(8'h44); send_byte(8'h55); send_eop(); settle();
    chk("ov_err", first(err_q), b1 + 1);
    chk("ov_nerr", err_q.size(), 1);
    chk("ov_none", pid_q.size() + done_q.size() + dat_q.size() + crc_q.size(), 0);
    chk("ov_idle", rx_busy, 0);

    // reset in GET_DATA
    clr_log();
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33);
    n_rst = 1'b0; #1;
    chk("mr_out", outv, 15'd0);
    repeat (2) @(posedge clk);
    #1 chk("mr_hold", outv, 15'd0);
    n_rst = 1'b1;
    clr_log();
    send_byte(8'h80); send_byte(8'h2D); send_eop(); settle();
    chk_ev("mr_pid", 0, 0, 8'h2D, ecyc + 1);
    chk("mr_done", first(done_q), ecyc + 1);
    chk("mr_none", err_q.size() + dat_q.size() + crc_q.size() + nd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/rrcu.md
# rrcu

Receive-side control unit for the USB AES path. It takes decoded bytes from the USB receiver one at a time, strips SYNC and classifies the PID. It then routes packet bytes into four FIFOs: PID, non-data (token/SOF fields), data payload and data CRC. Those are the same four FIFOs the transmit RCU drains, so a packet received here can be encrypted and sent back out unchanged.

## Interface
- MAX_DATA, 64, maximum data-packet payload bytes, CRC excluded.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe; rx_byte holds a new decoded byte.
- rx_byte  in  8  received byte.
- eop  in  1  one-cycle strobe; end of packet seen on the bus.
- pid_full, nd_full, data_full, dcrc_full  in  1 each  FIFO full flags.
- write_data  out  8  byte presented to every FIFO.
- pid_write, nd_write, data_write, dcrc_write  out  1 each  FIFO write strobes; at most one high per cycle.
- pkt_done  out  1  one-cycle pulse; packet accepted.
- pkt_error  out  1  one-cycle pulse; packet rejected.
- rx_busy  out  1  high in any state other than IDLE.

## Operation
- PID classification uses rx_byte[7:4] and the shared constants:
  - token: 0001, 1001, 0101, 1101.
  - data: 0011, 1011, 0111, 1111.
  - handshake: 0010, 1010, 1110, 0110.
  - SOF/special: 1100, 1000, 0100.
  - anything else is invalid.
- A PID is also invalid if rx_byte[3:0] != ~rx_byte[7:4].
- Expected byte count after the PID:
  - token and SOF: exactly 2.
  - handshake: 0.
  - data: 2 to MAX_DATA+2 bytes; the final 2 are CRC.
- States:
  - IDLE: waits for byte_valid with rx_byte==8'h80, then -> GET_PID. Any other byte or eop is ignored.
  - GET_PID: on byte, classify and latch the PID. Invalid -> ERROR. Handshake -> WAIT_EOP. Token/SOF -> GET_ND with nd_left=2. Data -> GET_DATA with count=0 and hold buffer empty. An eop here -> ERROR handling (pkt_error pulse, then IDLE).
  - GET_ND: each byte is written to the nd FIFO and nd_left decrements; at 0 -> WAIT_EOP. An eop while nd_left!=0 -> error.
  - GET_DATA: a two-byte hold buffer delays every byte. When a byte arrives with the buffer full, the oldest byte goes to the data FIFO and count increments. count would exceed MAX_DATA -> ERROR. On eop: buffer must hold exactly 2 bytes -> FLUSH_CRC1; otherwise error.
  - FLUSH_CRC1 / FLUSH_CRC2: write the older, then the newer held byte to the dcrc FIFO, then -> COMMIT.
  - WAIT_EOP: eop -> COMMIT. A byte arriving here -> ERROR.
  - COMMIT: write the latched PID to the PID FIFO, pulse pkt_done, -> IDLE.
  - ERROR: pulse pkt_error on entry, swallow bytes until eop, -> IDLE. When the error is caused by eop itself, pulse pkt_error and go directly to IDLE.
- The PID FIFO is written only for accepted packets. Bytes already pushed from a rejected packet stay in their FIFOs; downstream flushes on pkt_error.
- Overrun: if a write is due and the target FIFO's full flag is high, the byte is dropped and the block goes to ERROR. COMMIT with pid_full high also -> pkt_error, and no PID write occurs.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE; counters and hold buffer reset to 0.
- Write strobes assert the cycle after the byte_valid that caused them, with write_data valid in that same cycle.
- Byte spacing: at least 8 clk between byte_valid pulses (one USB byte period). eop comes at least 1 clk after the last byte.
- byte_valid and eop in the same cycle: the byte is processed first, then eop takes effect in that state's following decision.
- Latency:
  - The CRC writes land 1 and 2 cycles after eop.
  - pkt_done comes 1 cycle after eop for token/handshake/SOF packets, 3 cycles after eop for data packets.
- Reset asserted mid-packet: outputs clear immediately, no partial commit; the next packet must begin with SYNC.
- count width: $clog2(MAX_DATA+1).

## Structure
- usb_pkg (shared with the transmit RCU) holds: the SYNC constant 8'h80, the PID group localparams, and a pid_class_t enum {TOKEN, DATA, HAND, SPECIAL, INVALID} with a classify function.
- The state enum stays local to rrcu.
- One sub-module, crc_hold_buffer: a two-entry byte delay line with clear, push, pop_oldest and an occupancy output.

## Test plan
- Handshake: bytes 80, 2D, then eop -> single pid_write 2D, pkt_done 1 cycle after eop, no other writes.
- Token: bytes 80, 1E, A5, 3C, then eop -> nd_write A5 then 3C, pid_write 1E, pkt_done.
- Data: bytes 80, 3C, 11, 22, 33, C1, C2, then eop -> data_write 11, 22, 33; dcrc_write C1, C2 on eop+1 and eop+2; pid_write 3C; pkt_done at eop+3.
- Errors, each -> pkt_error and no pid_write:
  - bytes 80, 1F (bad check nibble);
  - bytes 80, 1E, A5, then eop (short token);
  - bytes 80, 3C, 11, then eop (CRC missing);
  - MAX_DATA+3 data bytes (payload overflow).
- Overrun: data_full high when the third payload byte arrives -> byte dropped, pkt_error, remaining bytes swallowed until eop, then IDLE.
- Reset during GET_DATA -> all outputs 0; next packet 80, 2D, eop completes normally.
